// File: rtl/w0rm_mem_pkg.sv
// Shared constants and FSM encoding for the w0rm instruction/data memory arbiter.
package w0rm_mem_pkg;

  localparam int unsigned ADDR_WIDTH_DEF   = 32;
  localparam int unsigned DATA_WIDTH_DEF   = 32;
  localparam int unsigned INST_WIDTH_DEF   = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/w0rm_mem_arb_select.sv
// Grant selection between fetch and data requests with a starvation counter
// that bounds how many data grants may pass a waiting fetch.
module w0rm_mem_arb_select
  import w0rm_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          idle,
  input  logic          if_req,
  input  logic          if_flush,
  input  logic          d_req,
  output logic          if_grant,
  output logic          d_grant,
  output logic [CW-1:0] starve_cnt
);

  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          if_eff;

  always_comb begin
    // A fetch request raised alongside a flush does not exist for arbitration.
    if_eff       = if_req & ~if_flush;
    d_grant      = idle & d_req & ((starve_cnt_q < LIMIT_C) | ~if_eff);
    if_grant     = idle & if_eff & ~d_grant;
    starve_cnt_d = starve_cnt_q;
    if (if_grant) begin
      starve_cnt_d = '0;
    end else if (d_grant && if_eff && (starve_cnt_q < LIMIT_C)) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end

  assign starve_cnt = starve_cnt_q;

endmodule

// File: rtl/w0rm_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between instruction fetch
// and load/store, with flush-discard of in-flight fetches.
module w0rm_mem_arbiter
  import w0rm_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned INST_WIDTH   = INST_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_accept,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_accept,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  discard_q, discard_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [INST_WIDTH-1:0] inst_data_q, inst_data_d;
  logic [ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
  logic                  d_done_q, d_done_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_grant, d_grant;
  logic [CW-1:0]         starve_cnt;

  w0rm_mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk       (clk),
    .reset_n   (reset_n),
    .idle      (state_q == IDLE),
    .if_req    (if_req),
    .if_flush  (if_flush),
    .d_req     (d_req),
    .if_grant  (if_grant),
    .d_grant   (d_grant),
    .starve_cnt(starve_cnt)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    discard_d    = discard_q;
    inst_valid_d = 1'b0;
    inst_data_d  = inst_data_q;
    inst_addr_d  = inst_addr_q;
    d_done_d     = 1'b0;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_grant) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (if_grant) begin
          state_d    = IF_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      IF_BUSY: begin
        if (if_flush) discard_d = 1'b1;
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          // A flush arriving in the ack cycle discards the response as well.
          if (!(discard_q || if_flush)) begin
            inst_valid_d = 1'b1;
            inst_addr_d  = mem_addr_q;
            inst_data_d  = mem_addr_q[1] ? mem_rdata[2*INST_WIDTH-1:INST_WIDTH]
                                         : mem_rdata[INST_WIDTH-1:0];
          end
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_done_d  = 1'b1;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_addr_q  <= '0;
      d_done_q     <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      discard_q    <= discard_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_addr_q  <= inst_addr_d;
      d_done_q     <= d_done_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_accept  = if_grant;
  assign d_accept   = d_grant;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_addr  = inst_addr_q;
  assign d_done     = d_done_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// Self-checking bench for w0rm_mem_arbiter: directed scenarios plus random
// traffic, all checked each cycle against a transaction-level model.
module tb_w0rm_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req, if_flush, if_accept, inst_valid;
  logic [AW-1:0] if_addr, inst_addr, d_addr, mem_addr;
  logic [IW-1:0] inst_data;
  logic          d_req, d_we, d_accept, d_done;
  logic [DW-1:0] d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack;

  always #5 clk = ~clk;

  w0rm_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INST_WIDTH(IW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_accept(if_accept),
    .inst_data(inst_data), .inst_addr(inst_addr), .inst_valid(inst_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_accept(d_accept), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: which transaction is outstanding (0 none, 1 fetch, 2 data) and what it carries.
  int          m_busy, m_starve, ack_cd, ack_lat;
  logic [31:0] m_addr, m_wdata, e_iaddr, e_drdata, rd_val;
  logic        m_we;
  bit          m_discard, e_iv, e_dd, rd_fixed, spurious;
  logic [15:0] e_idata;
  bit          last_if_acc, last_d_acc, last_iv, last_dd;

  task automatic model_reset();
    m_busy = 0; m_starve = 0; m_discard = 0; ack_cd = 0;
    e_iv = 0; e_dd = 0; e_idata = '0; e_iaddr = '0; e_drdata = '0;
  endtask

  task automatic step();
    bit pi, pd, ife;
    if (m_busy != 0) begin
      if (ack_cd == 0) begin
        mem_ack = 1'b1;
        mem_rdata = rd_fixed ? rd_val : $urandom;
      end else begin
        ack_cd--;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      mem_ack = spurious && ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
    @(negedge clk);
    ife = if_req && !if_flush;
    pd  = (m_busy == 0) && d_req && ((m_starve < LIM) || !ife);
    pi  = (m_busy == 0) && ife && !pd;
    check_eq("if_accept", 64'(if_accept), 64'(pi));
    check_eq("d_accept", 64'(d_accept), 64'(pd));
    check_eq("mem_req", 64'(mem_req), 64'(m_busy != 0));
    if (m_busy != 0) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
      check_eq("mem_we", 64'(mem_we), 64'(m_we));
      if (m_busy == 2) check_eq("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    check_eq("inst_valid", 64'(inst_valid), 64'(e_iv));
    check_eq("inst_data", 64'(inst_data), 64'(e_idata));
    check_eq("inst_addr", 64'(inst_addr), 64'(e_iaddr));
    check_eq("d_done", 64'(d_done), 64'(e_dd));
    check_eq("d_rdata", 64'(d_rdata), 64'(e_drdata));
    check_eq("starve_cnt", 64'(dut.u_sel.starve_cnt), 64'(m_starve));
    last_if_acc = if_accept; last_d_acc = d_accept;
    last_iv = inst_valid;    last_dd = d_done;
    e_iv = 0; e_dd = 0;
    if (m_busy == 1) begin
      if (if_flush) m_discard = 1;
      if (mem_ack) begin
        if (!m_discard) begin
          e_iv = 1;
          e_iaddr = m_addr;
          e_idata = m_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        end
        m_discard = 0;
        m_busy = 0;
      end
    end else if (m_busy == 2 && mem_ack) begin
      e_dd = 1;
      if (!m_we) e_drdata = mem_rdata;
      m_busy = 0;
    end
    if (pd) begin
      m_busy = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
      if (ife && m_starve < LIM) m_starve++;
      ack_cd = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
    end
    if (pi) begin
      m_busy = 1; m_addr = if_addr; m_we = 1'b0; m_starve = 0;
      ack_cd = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_accept(input bit want_d, input string tag);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = want_d ? last_d_acc : last_if_acc;
    end
    check_eq(tag, 64'(got), 64'(1));
  endtask

  task automatic drain(input int n);
    if_req = 0; d_req = 0; if_flush = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int nd, niv, ndd;
    bit fetched;
    reset_n = 1'b1;
    if_req = 0; if_addr = '0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    ack_lat = 2; rd_fixed = 0; rd_val = '0; spurious = 0;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_mem_req", 64'(mem_req), 64'(0));
    check_eq("rst_mem_we", 64'(mem_we), 64'(0));
    check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
    check_eq("rst_inst_valid", 64'(inst_valid), 64'(0));
    check_eq("rst_d_done", 64'(d_done), 64'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // single fetch, upper halfword
    ack_lat = 3; rd_fixed = 1; rd_val = 32'hBEEF_1234;
    if_addr = 32'h2000_0002; if_req = 1;
    run_until_accept(0, "t33_accept");
    if_req = 0;
    niv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_iv) begin
        niv++;
        check_eq("t33_inst_data", 64'(inst_data), 64'(16'hBEEF));
        check_eq("t33_inst_addr", 64'(inst_addr), 64'(32'h2000_0002));
      end
    end
    check_eq("t33_iv_pulses", 64'(niv), 64'(1));
    rd_fixed = 0;

    // contention: data wins LIM times, then fetch
    ack_lat = 0;
    d_req = 1; d_we = 0; d_addr = $urandom; if_req = 1; if_addr = 32'h0000_0300;
    nd = 0; fetched = 0;
    for (int i = 0; i < 60 && !fetched; i++) begin
      step();
      if (last_d_acc) begin nd++; d_addr = $urandom; end
      if (last_if_acc) fetched = 1;
    end
    check_eq("t34_data_wins", 64'(nd), 64'(LIM));
    check_eq("t34_fetched", 64'(fetched), 64'(1));
    check_eq("t34_starve_clear", 64'(dut.u_sel.starve_cnt), 64'(0));
    drain(8);

    // flush discards the outstanding fetch
    ack_lat = 4;
    if_addr = 32'h0000_0400; if_req = 1;
    run_until_accept(0, "t35_accept");
    if_req = 0;
    step();
    if_flush = 1; step(); if_flush = 0;
    niv = 0;
    for (int i = 0; i < 8; i++) begin step(); niv += int'(last_iv); end
    check_eq("t35_no_iv", 64'(niv), 64'(0));
    if_addr = 32'h0000_0406; if_req = 1;
    run_until_accept(0, "t35_next_accept");
    if_req = 0;
    niv = 0;
    for (int i = 0; i < 8; i++) begin step(); niv += int'(last_iv); end
    check_eq("t35_next_iv", 64'(niv), 64'(1));

    // store held on the bus until ack
    ack_lat = 3;
    d_req = 1; d_we = 1; d_addr = 32'h1000_0000; d_wdata = 32'hA5A5_A5A5;
    run_until_accept(1, "t36_accept");
    d_req = 0; d_we = 0;
    ndd = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) begin
        check_eq("t36_mem_we", 64'(mem_we), 64'(1));
        check_eq("t36_mem_addr", 64'(mem_addr), 64'(32'h1000_0000));
        check_eq("t36_mem_wdata", 64'(mem_wdata), 64'(32'hA5A5_A5A5));
      end
      step();
      ndd += int'(last_dd);
    end
    check_eq("t36_done_pulses", 64'(ndd), 64'(1));

    // reset while a load is in flight
    ack_lat = 5;
    d_req = 1; d_we = 0; d_addr = 32'h1234_5670;
    run_until_accept(1, "t37_accept");
    d_req = 0;
    step();
    #2 reset_n = 1'b0;
    #1;
    check_eq("t37_mem_req_async", 64'(mem_req), 64'(0));
    model_reset();
    ndd = 0;
    for (int i = 0; i < 3; i++) begin step(); ndd += int'(last_dd); end
    check_eq("t37_no_done", 64'(ndd), 64'(0));
    reset_n = 1'b1;
    d_req = 1; d_addr = 32'h55AA_0000;
    step();
    check_eq("t37_accept_after_reset", 64'(last_d_acc), 64'(1));
    d_req = 0;
    drain(10);

    // random traffic with spurious idle acks and flushes
    ack_lat = -1; spurious = 1;
    for (int i = 0; i < 800; i++) begin
      step();
      if (last_if_acc) if_req = 0;
      if (last_d_acc) d_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 9) == 0);
    end
    spurious = 0;
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/w0rm_mem_arbiter.md
W0RM_MEM_ARBITER -- requirements
Module: w0rm_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have parameter INST_WIDTH, default 16, instruction width returned to fetch.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive data grants while fetch waits.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports if_req, if_addr, input, 1/ADDR_WIDTH: fetch request, held until accepted.
REQ-009 SHALL have port if_flush, input, 1: branch flush that discards any outstanding fetch.
REQ-010 SHALL have port if_accept, output, 1: fetch request taken this cycle.
REQ-011 SHALL have ports inst_data, inst_addr, inst_valid, output, INST_WIDTH/ADDR_WIDTH/1: fetch response.
REQ-012 SHALL have ports d_req, d_we, d_addr, d_wdata, input, 1/1/ADDR_WIDTH/DATA_WIDTH: load/store request, held until accepted.
REQ-013 SHALL have ports d_accept, d_done, d_rdata, output, 1/1/DATA_WIDTH: accept, completion pulse, load data.
REQ-014 SHALL have ports mem_req, mem_we, mem_addr, mem_wdata, output, 1/1/ADDR_WIDTH/DATA_WIDTH: shared memory bus.
REQ-015 SHALL have ports mem_ack, mem_rdata, input, 1/DATA_WIDTH: one-cycle completion pulse, read data valid with it.

Function
REQ-016 SHALL implement FSM states IDLE, IF_BUSY, D_BUSY; exactly one transaction outstanding.
REQ-017 SHALL accept only in IDLE; if_accept and d_accept are combinational and mutually exclusive.
REQ-018 SHALL select data when d_req and (starve_cnt < STARVE_LIMIT or !if_req), else fetch when if_req and !if_flush.
REQ-019 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each data accept while if_req is high, and clear it on fetch accept.
REQ-020 SHALL register the accepted request onto mem_* at the accepting edge: mem_req high from the next cycle, address/data/we stable until mem_ack.
REQ-021 SHALL drive mem_we 0 for fetches and d_we for data transactions.
REQ-022 SHALL deassert mem_req and return to IDLE on the edge that samples mem_ack; the next accept is possible in that IDLE cycle.
REQ-023 SHALL pulse inst_valid or d_done for exactly one cycle, registered one cycle after mem_ack; d_done also pulses for stores.
REQ-024 SHALL select inst_data = mem_rdata[15:0] when mem_addr[1]=0, mem_rdata[31:16] when 1; inst_addr = fetched address.
REQ-025 SHALL hold d_rdata, inst_data, inst_addr stable between response pulses.
REQ-026 SHALL latch if_flush in IF_BUSY as a discard flag; the matching mem_ack then produces no inst_valid; the flag clears on that ack.
REQ-027 SHALL ignore if_req in a cycle where if_flush is high; if_flush in D_BUSY or IDLE has no other effect.
REQ-028 SHALL ignore mem_ack in IDLE.

Reset
REQ-029 SHALL, on reset_n low, immediately force IDLE, starve_cnt 0, discard flag 0, mem_req/mem_we/inst_valid/d_done 0, all address/data outputs 0, independent of clk.
REQ-030 SHALL abandon any in-flight transaction on reset with no response pulse; first accept possible on the first edge after reset_n rises.

Structure
REQ-031 SHALL take state encoding and default parameter constants from shared package w0rm_mem_pkg.
REQ-032 SHALL place grant selection and starve_cnt in sub-module w0rm_mem_arb_select; FSM and bus registers stay in the top.

Verification
REQ-033 SHALL verify single fetch: if_addr=0x2000_0002, mem_ack 3 cycles later with rdata 0xBEEF_1234 -> inst_valid one cycle, inst_data 0xBEEF.
REQ-034 SHALL verify contention: if_req and d_req held together -> data wins 4 times, then fetch granted, starve_cnt back to 0.
REQ-035 SHALL verify flush: fetch outstanding, if_flush pulse, then mem_ack -> no inst_valid; next if_req served normally.
REQ-036 SHALL verify store: d_we=1, d_addr=0x1000_0000, d_wdata=0xA5A5_A5A5 -> mem_we=1, same values on bus until ack, d_done one pulse.
REQ-037 SHALL verify reset mid-transaction: reset_n low while D_BUSY -> mem_req 0 without clock edge, no d_done; after release, new request accepted.
